// File: rtl/truth_table_sequencer.sv
// Sweeps a 3-input function block through {A,B,C} = 0..7, captures Y into an
// 8-bit truth table and compares it against an expected minterm mask.
module truth_table_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [7:0]  EXPECTED      = 8'hC0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       f_y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       pass,
    output logic [2:0] first_bad
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [7:0] final_table;

    // The last sample is still in flight when DONE is entered, so the verdict
    // is formed from the table with bit 7 already replaced by the live f_y.
    always_comb begin
        final_table    = table_out;
        final_table[7] = f_y;
    end

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 3'd0;
            cnt       <= 4'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            c         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= 8'h00;
            pass      <= 1'b0;
            first_bad <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!abort && start) begin
                        idx       <= 3'd0;
                        cnt       <= 4'd0;
                        {a, b, c} <= 3'd0;
                        table_out <= 8'h00;
                        pass      <= 1'b0;
                        first_bad <= 3'd0;
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        state     <= IDLE;
                        idx       <= 3'd0;
                        cnt       <= 4'd0;
                        {a, b, c} <= 3'd0;
                        table_out <= 8'h00;
                        pass      <= 1'b0;
                        first_bad <= 3'd0;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (cnt == CNT_LAST) state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        state     <= IDLE;
                        idx       <= 3'd0;
                        cnt       <= 4'd0;
                        {a, b, c} <= 3'd0;
                        table_out <= 8'h00;
                        pass      <= 1'b0;
                        first_bad <= 3'd0;
                        busy      <= 1'b0;
                    end else begin
                        table_out[idx] <= f_y;
                        if (idx == 3'd7) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (final_table == EXPECTED);
                            first_bad <= lowest_set(final_table ^ EXPECTED);
                        end else begin
                            idx       <= idx + 3'd1;
                            {a, b, c} <= idx + 3'd1;
                            cnt       <= 4'd0;
                            state     <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
